subtractor_64_bit_seq: RTL
==========================

Name: subtractor_64_bit_seq

Overview:
Multi-cycle 64-bit unsigned/two's-complement subtractor, D = X - Y. It is the inverse companion of the team's combinational 64-bit adder: given a sum and one operand, it recovers the other.
- Computation is slice-serial: SLICE bits per clock, rippling the carry through a register.
- Datapath area stays small.
- start/busy/done handshake, for use by sequential datapaths in the lab designs.

Parameters:
SLICE, 8, bits processed per cycle. Legal values: 1, 2, 4, 8, 16, 32, 64 (must divide 64). NSLICE = 64/SLICE is derived.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; operands sampled on the same edge
X  input  64  minuend
Y  input  64  subtrahend
busy  output  1  high while a subtraction is in progress
done  output  1  one-cycle pulse: D/borrow/ovf valid
D  output  64  difference X - Y, mod 2^64
borrow  output  1  1 when X < Y (unsigned)
ovf  output  1  signed two's-complement overflow of X - Y

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - busy=0, done=0, D=0, borrow=0, ovf=0.
  - Internal slice counter, operand registers and carry register are cleared.
  - Takes effect immediately, including mid-operation; the partial result is discarded.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge: latch X and Y into internal registers.
  - Set carry register = 1 (X + ~Y + 1), counter = 0, busy=1.
  - Go to RUN.
- RUN, one slice per edge, with k = counter:
  - {c_out, sum} = X[k*SLICE +: SLICE] + ~Y[k*SLICE +: SLICE] + carry.
  - D[k*SLICE +: SLICE] <= sum; carry <= c_out; counter += 1.
  - On the edge processing slice NSLICE-1:
    - borrow <= ~c_out.
    - ovf <= (X[63] != Y[63]) && (sum_msb != X[63]), using the latched operands.
    - done <= 1, busy <= 0, go to DONE.
- DONE lasts exactly one cycle; done=1 during it.
  - start=1 in DONE is accepted exactly as in IDLE: back-to-back operation, busy re-asserts on that edge, done falls.
  - Otherwise go to IDLE, done <= 0.
- Latency:
  - start sampled at edge t.
  - Results valid and done=1 after edge t+NSLICE.
  - Next start accepted at edge t+NSLICE+1 at the earliest.
- start while busy (RUN) is ignored; the operands in flight are unaffected. X and Y may change freely after the sampling edge.
- D, borrow and ovf hold their last values in IDLE until the next completed operation.
- D bits of slices not yet processed hold stale values during RUN; D is only valid with done or in IDLE.
- SLICE=64: one RUN cycle, so done arrives after edge t+1.
- Arithmetic is modulo 2^64; no saturation.

Test Plan:
- Default SLICE=8, start with X=13800223, Y=13800121:
  - done exactly 8 cycles after start, busy high for those 8 cycles.
  - D=102, borrow=0, ovf=0.
- Three back-to-back operations, start held in each DONE cycle:
  - X=23, Y=21 -> D=2, borrow=0.
  - Then X=21, Y=23 -> D=0xFFFFFFFFFFFFFFFE, borrow=1, ovf=0.
  - Then X=400, Y=22 -> D=378.
  - Each done is a single-cycle pulse.
- X=0x8000000000000000, Y=1 -> D=0x7FFFFFFFFFFFFFFF, ovf=1, borrow=0.
- X=57, Y=57 -> D=0, borrow=0, ovf=0.
- Start X=75, Y=4; at cycle 3 pulse start with X=1, Y=1 (ignored); at cycle 5 drive rst_n=0 asynchronously (mid-clock):
  - Outputs go to 0 immediately.
  - After release, start X=75, Y=4 -> D=71 with correct latency.
- Re-run all vectors with SLICE=1 and SLICE=64:
  - Results are identical.
  - Latency is 64 and 1 cycles respectively.

Source files
------------

// File: rtl/subtractor_64_bit_seq.sv
// Slice-serial 64-bit subtractor: D = X - Y, with unsigned borrow and signed overflow flags.
// Latency: NSLICE = 64/SLICE cycles from the start edge to the done pulse; next start accepted in the done cycle.
// Backpressure: none; start is ignored while busy, and results hold until the next operation completes.
module subtractor_64_bit_seq #(
  parameter int SLICE = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] X,
  input  logic [63:0] Y,
  output logic        busy,
  output logic        done,
  output logic [63:0] D,
  output logic        borrow,
  output logic        ovf
);

  localparam int NSLICE = 64 / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NSLICE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   x_q, x_d;
  logic [63:0]   y_q, y_d;
  logic          carry_q, carry_d;
  logic [63:0]   d_q, d_d;
  logic          borrow_q, borrow_d;
  logic          ovf_q, ovf_d;

  logic          accept_c;
  logic          last_c;
  logic [5:0]    base_c;
  logic [SLICE-1:0] xs_c, ys_c;
  logic [SLICE:0]   sum_c;

  // One slice of X + ~Y + carry; the slice base is counter * SLICE.
  always_comb begin
    base_c   = 6'(cnt_q) * 6'(SLICE);
    xs_c     = x_q[base_c +: SLICE];
    ys_c     = y_q[base_c +: SLICE];
    sum_c    = {1'b0, xs_c} + {1'b0, ~ys_c} + {{SLICE{1'b0}}, carry_q};
    last_c   = (cnt_q == LAST_CNT);
    accept_c = start && (state_q != S_RUN);
  end

  // Next-state logic: DONE lasts one cycle unless a new start chains straight into RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_c) state_d = S_DONE;
      S_DONE:  state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: latch operands on accept, otherwise ripple one slice per RUN cycle.
  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    d_d      = d_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    if (accept_c) begin
      x_d     = X;
      y_d     = Y;
      carry_d = 1'b1;
      cnt_d   = '0;
    end else if (state_q == S_RUN) begin
      d_d[base_c +: SLICE] = sum_c[SLICE-1:0];
      carry_d = sum_c[SLICE];
      cnt_d   = cnt_q + CW'(1);
      if (last_c) begin
        // Carry out of X + ~Y + 1 is the inverted borrow; the top slice's MSB is bit 63.
        borrow_d = ~sum_c[SLICE];
        ovf_d    = (x_q[63] ^ y_q[63]) & (sum_c[SLICE-1] ^ x_q[63]);
      end
    end
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      carry_q  <= 1'b0;
      d_q      <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      y_q      <= y_d;
      carry_q  <= carry_d;
      d_q      <= d_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end

  // Handshake outputs decode directly from the state register.
  always_comb begin
    busy   = (state_q == S_RUN);
    done   = (state_q == S_DONE);
    D      = d_q;
    borrow = borrow_q;
    ovf    = ovf_q;
  end

endmodule
